// File: rtl/sine_sample_fifo.sv
// sine_sample_fifo
//   Captures the sine generator output on each rising edge of a divided
//   sample tick into a circular FIFO and exposes it to the CPU through an
//   Avalon-MM slave. A programmable fill threshold raises a level interrupt
//   so software can drain captured waveform blocks.
//
// Ports
//   Clk           system clock, all logic on its rising edge
//   Reset         synchronous, active-high reset
//   ChipSelect    Avalon slave select
//   Write, Read   Avalon strobes, qualified by ChipSelect
//   Address       register select: 0 CTRL, 1 STATUS, 2 DATA, 3 THRESH
//   WriteData     Avalon write data
//   ReadData      registered read data, latency 1, holds when idle
//   iData_sin     sample from the sine generator
//   iSample_tick  divided sample clock, used as a level in the Clk domain
//   irq           threshold interrupt, level-sensitive
module sine_sample_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 64,
    parameter int LVL_W  = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ChipSelect,
    input  logic              Write,
    input  logic              Read,
    input  logic [1:0]        Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [DATA_W-1:0] iData_sin,
    input  logic              iSample_tick,
    output logic              irq
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] THRESH_RST = LVL_W'(DEPTH / 2);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level, level_next, thresh, thresh_wr;
    logic              capture_en, irq_en, one_shot;
    logic              overflow, pending, tick_d;

    logic              wr_cs, rd_cs, flush, pop, push_req, push;
    logic              empty, full, pend_set, drop;
    logic              wr_ctrl, wr_status, wr_thresh;
    logic [31:0]       rd_mux;

    logic              unused_wdata;
    assign unused_wdata = &{1'b0, WriteData[31:12], WriteData[9:7]};

    always_comb begin
        wr_cs     = ChipSelect & Write;
        rd_cs     = ChipSelect & Read;
        wr_ctrl   = wr_cs && (Address == ADDR_CTRL);
        wr_status = wr_cs && (Address == ADDR_STATUS);
        wr_thresh = wr_cs && (Address == ADDR_THRESH);

        empty     = (level == '0);
        full      = (level == FULL_LVL);
        flush     = wr_ctrl && WriteData[2];

        push_req  = iSample_tick & ~tick_d & capture_en;
        // Flush wins over any push or pop in the same cycle.
        pop       = rd_cs && (Address == ADDR_DATA) && !empty && !flush;
        // A simultaneous pop frees a slot, so a push into a full FIFO is accepted.
        push      = push_req && (!full || pop) && !flush;
        drop      = push_req && full && !pop && !flush;

        level_next = level;
        if (push && !pop)
            level_next = level + LVL_W'(1);
        else if (pop && !push)
            level_next = level - LVL_W'(1);

        // Edge-detect the crossing so a level parked above the threshold,
        // or a threshold rewritten below it, never re-raises pending.
        pend_set = (thresh != '0) && (level < thresh) && (level_next >= thresh) && !flush;

        thresh_wr = (WriteData[LVL_W-1:0] > FULL_LVL) ? FULL_LVL : WriteData[LVL_W-1:0];

        rd_mux = '0;
        case (Address)
            ADDR_CTRL: begin
                rd_mux[0] = capture_en;
                rd_mux[1] = irq_en;
                rd_mux[3] = one_shot;
            end
            ADDR_STATUS: begin
                rd_mux[LVL_W-1:0] = level;
                rd_mux[8]         = empty;
                rd_mux[9]         = full;
                rd_mux[10]        = overflow;
                rd_mux[11]        = pending;
            end
            ADDR_DATA: begin
                if (!empty) begin
                    rd_mux[DATA_W-1:0] = mem[rd_ptr];
                    rd_mux[31]         = 1'b1;
                end
            end
            default: rd_mux[LVL_W-1:0] = thresh;
        endcase
    end

    // Sample storage is kept out of the reset domain; level gates visibility.
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= iData_sin;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ReadData   <= '0;
            irq        <= 1'b0;
            capture_en <= 1'b0;
            irq_en     <= 1'b0;
            one_shot   <= 1'b0;
            level      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            pending    <= 1'b0;
            thresh     <= THRESH_RST;
            tick_d     <= 1'b0;
        end else begin
            tick_d <= iSample_tick;
            irq    <= pending & irq_en;

            if (rd_cs)
                ReadData <= rd_mux;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_next;

            // Software clears are ordered before hardware sets so a set wins.
            if (wr_status && WriteData[10])
                overflow <= 1'b0;
            if (wr_status && WriteData[11])
                pending <= 1'b0;
            if (pend_set)
                pending <= 1'b1;

            // Hardware clears of capture_en come before the CTRL write so an
            // explicit software write takes precedence.
            if (drop) begin
                if (one_shot)
                    capture_en <= 1'b0;
                else
                    overflow <= 1'b1;
            end
            if (push && one_shot && (level_next == FULL_LVL))
                capture_en <= 1'b0;

            if (wr_ctrl) begin
                capture_en <= WriteData[0];
                irq_en     <= WriteData[1];
                one_shot   <= WriteData[3];
            end
            if (wr_thresh)
                thresh <= thresh_wr;

            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                pending <= 1'b0;
            end
        end
    end

endmodule
